// File: rtl/riscv_decode_queue.sv
// Decode/buffer stage feeding issue: classifies fetched instructions at push
// time and holds up to DEPTH decoded entries in a flushable FIFO.
module riscv_decode_queue #(
  parameter int DEPTH          = 2,
  parameter bit SUPPORT_MULDIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_in_valid,
  input  logic [31:0] fetch_in_instr,
  input  logic [31:0] fetch_in_pc,
  input  logic        fetch_in_fault_fetch,
  input  logic        fetch_in_fault_page,
  output logic        fetch_in_accept,
  input  logic        branch_request,
  output logic        fetch_out_valid,
  output logic [31:0] fetch_out_instr,
  output logic [31:0] fetch_out_pc,
  output logic        fetch_out_fault_fetch,
  output logic        fetch_out_fault_page,
  output logic        fetch_out_is_exec,
  output logic        fetch_out_is_lsu,
  output logic        fetch_out_is_branch,
  output logic        fetch_out_is_mul,
  output logic        fetch_out_is_div,
  output logic        fetch_out_is_csr,
  output logic        fetch_out_rd_valid,
  output logic        fetch_out_is_invalid,
  input  logic        fetch_out_accept
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc    [DEPTH];
  logic [1:0]    r_fault [DEPTH];
  logic [7:0]    r_flags [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic       w_push;
  logic       w_pop;
  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_exec, w_lsu, w_branch, w_mul, w_div, w_csr, w_rd_wr, w_bad;
  logic [7:0] w_flags;

  assign fetch_in_accept = (r_count != FULL);
  assign fetch_out_valid = (r_count != '0);
  assign w_push = fetch_in_valid & fetch_in_accept & ~branch_request;
  assign w_pop  = fetch_out_valid & fetch_out_accept;

  assign w_opc = fetch_in_instr[6:0];
  assign w_f3  = fetch_in_instr[14:12];
  assign w_f7  = fetch_in_instr[31:25];

  always_comb begin
    w_exec   = 1'b0;
    w_lsu    = 1'b0;
    w_branch = 1'b0;
    w_mul    = 1'b0;
    w_div    = 1'b0;
    w_csr    = 1'b0;
    w_rd_wr  = 1'b0;
    w_bad    = 1'b0;
    case (w_opc)
      7'b0110111, 7'b0010111, 7'b0010011: begin
        w_exec  = 1'b1;
        w_rd_wr = 1'b1;
      end
      7'b0110011: begin
        if (w_f7 == 7'b0000000 || w_f7 == 7'b0100000) begin
          w_exec  = 1'b1;
          w_rd_wr = 1'b1;
        end else if (w_f7 == 7'b0000001 && SUPPORT_MULDIV) begin
          w_mul   = ~w_f3[2];
          w_div   = w_f3[2];
          w_rd_wr = 1'b1;
        end else begin
          w_bad = 1'b1;
        end
      end
      7'b1101111: begin
        w_exec   = 1'b1;
        w_branch = 1'b1;
        w_rd_wr  = 1'b1;
      end
      7'b1100111: begin
        w_exec   = (w_f3 == 3'b000);
        w_branch = (w_f3 == 3'b000);
        w_rd_wr  = (w_f3 == 3'b000);
        w_bad    = (w_f3 != 3'b000);
      end
      7'b1100011: begin
        w_bad    = (w_f3 == 3'b010 || w_f3 == 3'b011);
        w_exec   = ~w_bad;
        w_branch = ~w_bad;
      end
      7'b0000011: begin
        w_bad   = (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111);
        w_lsu   = ~w_bad;
        w_rd_wr = ~w_bad;
      end
      7'b0100011: begin
        w_bad = w_f3[2] | (w_f3[1] & w_f3[0]);
        w_lsu = ~w_bad;
      end
      7'b0001111: w_exec = 1'b1;
      7'b1110011: begin
        w_bad   = (w_f3 == 3'b100);
        w_csr   = ~w_bad;
        w_rd_wr = (w_f3 != 3'b000) & ~w_bad;
      end
      default: w_bad = 1'b1;
    endcase

    // Faults and illegal encodings are both routed to the CSR/trap unit.
    if (fetch_in_fault_fetch | fetch_in_fault_page)
      w_flags = 8'b0000_0100;
    else if (w_bad)
      w_flags = 8'b0000_0101;
    else
      w_flags = {w_exec, w_lsu, w_branch, w_mul, w_div, w_csr,
                 w_rd_wr & (fetch_in_instr[11:7] != 5'd0), 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
        r_fault[i] <= '0;
        r_flags[i] <= '0;
      end
    end else if (branch_request) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_instr[r_wr_ptr] <= fetch_in_instr;
        r_pc[r_wr_ptr]    <= fetch_in_pc;
        r_fault[r_wr_ptr] <= {fetch_in_fault_fetch, fetch_in_fault_page};
        r_flags[r_wr_ptr] <= w_flags;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign fetch_out_instr       = r_instr[r_rd_ptr];
  assign fetch_out_pc          = r_pc[r_rd_ptr];
  assign fetch_out_fault_fetch = r_fault[r_rd_ptr][1];
  assign fetch_out_fault_page  = r_fault[r_rd_ptr][0];
  assign fetch_out_is_exec     = r_flags[r_rd_ptr][7];
  assign fetch_out_is_lsu      = r_flags[r_rd_ptr][6];
  assign fetch_out_is_branch   = r_flags[r_rd_ptr][5];
  assign fetch_out_is_mul      = r_flags[r_rd_ptr][4];
  assign fetch_out_is_div      = r_flags[r_rd_ptr][3];
  assign fetch_out_is_csr      = r_flags[r_rd_ptr][2];
  assign fetch_out_rd_valid    = r_flags[r_rd_ptr][1];
  assign fetch_out_is_invalid  = r_flags[r_rd_ptr][0];

endmodule

// File: doc/riscv_decode_queue.md
Name: riscv_decode_queue

Overview:
- Decode/buffer stage directly upstream of the issue stage.
- Accepts raw fetch responses (instruction, PC, fault flags) and classifies each instruction into exec/LSU/branch/mul/div/CSR types.
- Holds up to DEPTH decoded entries in a FIFO.
- Presents the head entry to issue with a valid/accept handshake.
- Flushes all entries on a branch/redirect request.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, 2..8.
- SUPPORT_MULDIV, 1, 1 = decode M-extension ops as mul/div; 0 = flag them invalid.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous, active-high reset (asserted = 1)
- fetch_in_valid  input  1  fetch response valid
- fetch_in_instr  input  32  raw instruction
- fetch_in_pc  input  32  instruction PC
- fetch_in_fault_fetch  input  1  bus fault on fetch
- fetch_in_fault_page  input  1  instruction page fault
- fetch_in_accept  output  1  queue can take the response this cycle
- branch_request  input  1  redirect/flush (from issue br_req_out)
- fetch_out_valid  output  1  head entry valid
- fetch_out_instr  output  32  head instruction
- fetch_out_pc  output  32  head PC
- fetch_out_fault_fetch  output  1  head fetch fault
- fetch_out_fault_page  output  1  head page fault
- fetch_out_is_exec  output  1  ALU/jump class
- fetch_out_is_lsu  output  1  load/store class
- fetch_out_is_branch  output  1  branch/jump
- fetch_out_is_mul  output  1  multiply
- fetch_out_is_div  output  1  divide/remainder
- fetch_out_is_csr  output  1  CSR/system/trap-routed
- fetch_out_rd_valid  output  1  writes rd (rd != 0)
- fetch_out_is_invalid  output  1  illegal instruction
- fetch_out_accept  input  1  issue consumed head this cycle

Behaviour:
- Reset: wr_ptr, rd_ptr, count = 0. fetch_out_valid = 0, fetch_in_accept = 1. All stored entries and decode flags = 0.
- Push when fetch_in_valid & fetch_in_accept & ~branch_request. Pop when fetch_out_valid & fetch_out_accept.
- fetch_in_accept = (count != DEPTH). It is not pop-aware: when full, a same-cycle pop does not enable a push.
- fetch_out_valid = (count != 0).
- All fetch_out_* come from registered storage at rd_ptr. No combinational path from fetch_in_* to fetch_out_*; minimum latency is 1 cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- branch_request (highest priority after reset): next cycle count = 0 and pointers = 0. A same-cycle push is dropped; a same-cycle pop is ignored.
- Decode is performed at push, on fetch_in_instr; opc = instr[6:0], f3 = [14:12], f7 = [31:25].
  - LUI 0110111, AUIPC 0010111, OP-IMM 0010011, OP 0110011 with f7 ∈ {0000000, 0100000}: is_exec, rd writes.
  - OP with f7 = 0000001: f3[2] = 0 gives is_mul, f3[2] = 1 gives is_div; rd writes. If SUPPORT_MULDIV = 0, the instruction is invalid instead.
  - JAL 1101111, or JALR 1100111 with f3 = 000: is_exec + is_branch, rd writes.
  - BRANCH 1100011 with f3 ∉ {010, 011}: is_exec + is_branch, no rd.
  - LOAD 0000011 with f3 ∈ {000, 001, 010, 100, 101}: is_lsu, rd writes.
  - STORE 0100011 with f3 ∈ {000, 001, 010}: is_lsu, no rd.
  - MISC-MEM 0001111 (fence): is_exec, no rd.
  - SYSTEM 1110011: f3 = 000 gives is_csr, no rd. f3 ∈ {001, 010, 011, 101, 110, 111} gives is_csr, rd writes. f3 = 100 is invalid.
  - Anything else: invalid.
  - Invalid instruction: is_invalid = 1, is_csr = 1, all other flags 0.
  - rd_valid = rd-writes & (instr[11:7] != 0).
- Faulting push (either fault flag set): the instruction is stored as received but all class flags are forced to 0 except is_csr = 1; is_invalid = 0. Fault flags propagate unchanged.
- Reset asserted mid-operation: all entries are discarded next cycle, identical to the reset state.

Test Plan:
- Reset, then push 0x00500093 (addi x1,x0,5) at PC 0x80000000 with accept held 1 → next cycle fetch_out_valid = 1, is_exec = 1, rd_valid = 1, all other flags 0; popped the following cycle; count returns to 0.
- With fetch_out_accept = 0, push 3 instructions (DEPTH = 2) → fetch_in_accept = 0 after the 2nd. The 3rd is held by fetch. Raising accept then drains the entries in order at PCs 0x0, 0x4.
- Push 0x02208033 (mul), 0x0220C033 (div), 0x00002083 (lw x1), 0x00102023 (sw) → flags is_mul; is_div; is_lsu + rd_valid; is_lsu with rd_valid = 0. With SUPPORT_MULDIV = 0, the first two give is_invalid = 1, is_csr = 1.
- Full queue plus a same-cycle push and branch_request = 1 → next cycle fetch_out_valid = 0, count = 0, and the pushed instruction never appears.
- Push with fetch_in_fault_page = 1, instr 0xFFFFFFFF → fetch_out_fault_page = 1, is_csr = 1, is_invalid = 0, all other flags 0.
- Push 0x00000013 (addi x0,x0,0) and 0x30200073 (mret) → first: is_exec = 1, rd_valid = 0. Second: is_csr = 1, rd_valid = 0, is_invalid = 0.
